// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory port and IF/ID outputs.
// master = fetch stage side, slave = surrounding pipeline / memory side.
interface fetch_stage_if #(
  parameter int N = 32
);
  logic         stall;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic [N-1:0] pc;
  logic [N-1:0] instruction;
  logic [N-1:0] pc_out;
  logic [N-1:0] instruction_out;
  logic         valid_out;
  logic         halted;
  logic         addr_err;

  modport master (
    input  stall, branch_taken, branch_target, instruction,
    output pc, pc_out, instruction_out, valid_out, halted, addr_err
  );

  modport slave (
    output stall, branch_taken, branch_target, instruction,
    input  pc, pc_out, instruction_out, valid_out, halted, addr_err
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-indexed PC, IF/ID register, IDLE/RUN/HALT control.
// Optional FETCH_PERF_CNT_EN adds a saturating fetch_count output.
module fetch_stage #(
  parameter int N   = 32,
  parameter int INS = 1000
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]    fetch_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [N-1:0] LAST_PC = N'(INS - 1);
  localparam logic [N:0]   DEPTH   = (N + 1)'(INS);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] pc_out_q, pc_out_d;
  logic [N-1:0] instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic         err_q, err_d;
  logic         capture;
  logic         target_ok;

  assign target_ok = ({1'b0, bus.branch_target} < DEPTH);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    err_d    = err_q;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_d    = '0;
        valid_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (bus.branch_taken) begin
          valid_d = 1'b0;
          if (target_ok) begin
            pc_d = bus.branch_target;
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end else if (!bus.stall) begin
          capture  = 1'b1;
          pc_out_d = pc_q;
          instr_d  = bus.instruction;
          valid_d  = 1'b1;
          // Last word: capture it but park the PC instead of wrapping.
          if (pc_q == LAST_PC) state_d = HALT;
          else                 pc_d    = pc_q + N'(1);
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (bus.branch_taken) begin
          if (target_ok) begin
            pc_d    = bus.branch_target;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (capture && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign fetch_count = cnt_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

  assign bus.pc              = pc_q;
  assign bus.pc_out          = pc_out_q;
  assign bus.instruction_out = instr_q;
  assign bus.valid_out       = valid_q;
  assign bus.halted          = halted_q;
  assign bus.addr_err        = err_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter N, default 32, SHALL set the width of the PC and instruction datapaths.
REQ-002 Parameter INS, default 1000, SHALL set the instruction-memory depth in words; valid PC range is 0..INS-1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 stall  input  1  SHALL be the hazard hold request from the decode stage.
REQ-006 branch_taken  input  1  SHALL be the redirect request from the execute stage.
REQ-007 branch_target  input  N  SHALL be the word-index redirect address.
REQ-008 pc  output  N  SHALL be the word index driven to instruction memory.
REQ-009 instruction  input  N  SHALL be the combinational instruction-memory read data for pc.
REQ-010 pc_out  output  N  SHALL be the IF/ID-registered PC.
REQ-011 instruction_out  output  N  SHALL be the IF/ID-registered instruction.
REQ-012 valid_out  output  1  SHALL mark the IF/ID contents as a real instruction.
REQ-013 halted  output  1  SHALL be high while the FSM is in HALT.
REQ-014 addr_err  output  1  SHALL be a sticky flag for an out-of-range branch target.

Function
REQ-015 FSM SHALL have states IDLE, RUN and HALT.
REQ-016 IDLE SHALL last exactly one cycle after reset: pc=0, no capture, valid_out=0; next state RUN.
REQ-017 In RUN, instruction SHALL be captured into IF/ID with pc at the same edge: 1-cycle latency from pc to instruction_out, and valid_out=1.
REQ-018 Per-edge priority in RUN SHALL be rst > branch_taken > stall > advance.
REQ-019 Advance: pc SHALL increment by 1 (word indexing, not byte).
REQ-020 Stall without branch: pc, pc_out, instruction_out and valid_out SHALL all hold.
REQ-021 Branch with branch_target < INS: pc SHALL load branch_target, IF/ID SHALL be flushed (valid_out=0) on the same edge, and stall SHALL be ignored.
REQ-022 Branch with branch_target >= INS: pc SHALL hold, IF/ID SHALL flush, addr_err SHALL set, and the FSM SHALL go to HALT.
REQ-023 An advance with pc==INS-1 SHALL capture that instruction (valid_out=1), hold pc at INS-1, and go to HALT; pc SHALL never wrap to 0.
REQ-024 In HALT: pc SHALL hold, valid_out SHALL be 0 from the next edge onward, and stall SHALL be ignored.
REQ-025 In HALT, a branch with an in-range target SHALL load pc, keep valid_out=0, and return the FSM to RUN.
REQ-026 halted SHALL be a registered decode of state==HALT.

Reset
REQ-027 On rst=1 at an edge: state=IDLE, pc=0, pc_out=0, instruction_out=0, valid_out=0, halted=0, addr_err=0, and the perf counter (if built) =0.
REQ-028 Reset asserted mid-stall, mid-branch or in HALT SHALL override all other inputs on that edge.

Configuration
REQ-029 With macro FETCH_PERF_CNT_EN defined, output fetch_count (32 bits) SHALL increment on every edge where valid_out is newly loaded with 1, and SHALL saturate at 0xFFFFFFFF.
REQ-030 Without FETCH_PERF_CNT_EN, the fetch_count port and counter logic SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-031 Reset, then 4 free-run cycles -> pc sequence 0,0,1,2,3; valid_out low in cycle 1, then instruction_out=mem[0],mem[1],mem[2].
REQ-032 stall=1 for 3 cycles at pc=5 -> pc stays 5, instruction_out stays mem[4], valid_out stays 1; resumes at pc=6.
REQ-033 branch_taken=1, target=20, stall=1 on the same edge -> pc=20, valid_out=0 next cycle, instruction_out=mem[20] the cycle after.
REQ-034 INS=8, free-run from reset -> valid_out=1 with instruction_out=mem[7] once, then halted=1, pc holds 7 and valid_out=0.
REQ-035 In HALT, branch to 2 -> halted=0 and pc=2 after one edge; branch to INS+3 -> addr_err=1, halted=1, pc unchanged.
REQ-036 With FETCH_PERF_CNT_EN, run 10 advances, 2 stalls and 1 branch -> fetch_count equals the number of valid_out rising loads, with no count during stall or flush.
